vstream_rx_meas: RTL and testbench

- Synthesizable receiving end of the team's pixel stream interface (di/de/hs/vs), i.e. what mult_v1 and the filter chain emit.
- Registers the stream, tags each pixel with x/y coordinates and measures active frame geometry.
- Flags timing violations and reports per-frame results.
- Sits at the output of a filter chain, in front of frame writers and debug registers.

---
 rtl/vstream_pkg.sv | 17 +
 rtl/vstream_rx_meas_if.sv | 48 ++++
 rtl/vstream_rx_meas.sv | 153 +++++++++++++++
 tb/tb_vstream_rx_meas.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vstream_pkg.sv
// Shared types and error-bit positions for the pixel stream receiver/measurement block.
package vstream_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        FWAIT  = 2'd1,
        HBLANK = 2'd2,
        LINE   = 2'd3
    } state_e;

    localparam int ERR_WIDTH    = 0;
    localparam int ERR_HEIGHT   = 1;
    localparam int ERR_DE_BLANK = 2;
    localparam int ERR_OVF      = 3;
    localparam int ERR_NUM      = 4;

endpackage

// File: rtl/vstream_rx_meas_if.sv
// Pixel stream in, delayed stream plus per-frame measurements out.
// Optional csum_o exists only when VSTREAM_RX_CHECKSUM_EN is defined.
interface vstream_rx_meas_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int XW          = 13,
    parameter int YW          = 13
);
    // Stream has no backpressure: de_i qualifies di_i in the same cycle and the
    // receiver accepts every cycle; de_o qualifies do_o/x_o/y_o one clock later.
    logic [3*PIXEL_WIDTH-1:0] di_i;
    logic                     de_i;
    logic                     hs_i;
    logic                     vs_i;
    logic [3*PIXEL_WIDTH-1:0] do_o;
    logic                     de_o;
    logic                     hs_o;
    logic                     vs_o;
    logic [XW-1:0]            x_o;
    logic [YW-1:0]            y_o;
    logic                     meas_vld_o;
    logic [XW-1:0]            width_o;
    logic [YW-1:0]            height_o;
    logic [15:0]              frame_cnt_o;
    logic [3:0]               err_o;
    logic [1:0]               state_o;
`ifdef VSTREAM_RX_CHECKSUM_EN
    logic [31:0]              csum_o;
`endif

    modport master (
        output di_i, de_i, hs_i, vs_i,
        input  do_o, de_o, hs_o, vs_o, x_o, y_o, meas_vld_o, width_o, height_o,
        input  frame_cnt_o, err_o, state_o
`ifdef VSTREAM_RX_CHECKSUM_EN
        , input csum_o
`endif
    );

    modport slave (
        input  di_i, de_i, hs_i, vs_i,
        output do_o, de_o, hs_o, vs_o, x_o, y_o, meas_vld_o, width_o, height_o,
        output frame_cnt_o, err_o, state_o
`ifdef VSTREAM_RX_CHECKSUM_EN
        , output csum_o
`endif
    );

endinterface

// File: rtl/vstream_rx_meas.sv
// Registers the pixel stream, tags pixels with x/y and measures frame geometry and errors.
// Define VSTREAM_RX_CHECKSUM_EN to add a per-frame pixel component checksum on csum_o.
module vstream_rx_meas
    import vstream_pkg::*;
#(
    parameter  int PIXEL_WIDTH     = 8,
    parameter  int LINE_SIZE_MAX   = 4096,
    parameter  int FRAME_LINES_MAX = 4096,
    localparam int XW              = $clog2(LINE_SIZE_MAX + 1),
    localparam int YW              = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    vstream_rx_meas_if.slave bus
);

    localparam logic [1:0] ST_SYNC   = 2'(SYNC);
    localparam logic [1:0] ST_FWAIT  = 2'(FWAIT);
    localparam logic [1:0] ST_HBLANK = 2'(HBLANK);
    localparam logic [1:0] ST_LINE   = 2'(LINE);

    logic [1:0]         state;
    logic [XW-1:0]      xcnt, line_ref, x_base, x_next, ref_next;
    logic [YW-1:0]      ycnt, y_next, ref_height;
    logic               ref_height_vld;
    logic [ERR_NUM-1:0] err_sticky, err_now, err_final;
    logic               line_cycle, pix, x_sat, y_sat, line_close, frame_end;

    assign bus.state_o = state;

    // A cycle with vs high and hs low is inside a line even on the cycle the FSM
    // is still leaving FWAIT/HBLANK, so the first pixel of a line is never lost.
    always_comb begin
        line_cycle = (state != ST_SYNC) && bus.vs_i && !bus.hs_i;
        x_base     = (state == ST_LINE) ? xcnt : '0;
        pix        = line_cycle && bus.de_i;
        x_sat      = (x_base == XW'(LINE_SIZE_MAX));
        x_next     = x_base;
        if (pix && !x_sat) x_next = x_base + XW'(1);

        line_close = (state == ST_LINE) && bus.hs_i;
        y_sat      = (ycnt == YW'(FRAME_LINES_MAX));
        y_next     = ycnt;
        if (line_close && !y_sat) y_next = ycnt + YW'(1);
        ref_next   = line_ref;
        if (line_close && (ycnt == '0)) ref_next = xcnt;

        err_now = err_sticky;
        if (line_close && (ycnt != '0) && (xcnt != line_ref)) err_now[ERR_WIDTH] = 1'b1;
        if ((state != ST_SYNC) && bus.de_i && (bus.hs_i || !bus.vs_i)) err_now[ERR_DE_BLANK] = 1'b1;
        if ((pix && x_sat) || (line_close && y_sat)) err_now[ERR_OVF] = 1'b1;

        frame_end = ((state == ST_HBLANK) || (state == ST_LINE)) && !bus.vs_i;
        err_final = err_now;
        if (ref_height_vld && (y_next != ref_height)) err_final[ERR_HEIGHT] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.do_o        <= '0;
            bus.de_o        <= 1'b0;
            bus.hs_o        <= 1'b0;
            bus.vs_o        <= 1'b0;
            bus.x_o         <= '0;
            bus.y_o         <= '0;
            bus.meas_vld_o  <= 1'b0;
            bus.width_o     <= '0;
            bus.height_o    <= '0;
            bus.frame_cnt_o <= '0;
            bus.err_o       <= '0;
            state           <= ST_SYNC;
            xcnt            <= '0;
            ycnt            <= '0;
            line_ref        <= '0;
            ref_height      <= '0;
            ref_height_vld  <= 1'b0;
            err_sticky      <= '0;
        end else begin
            bus.do_o       <= bus.di_i;
            bus.de_o       <= bus.de_i;
            bus.hs_o       <= bus.hs_i;
            bus.vs_o       <= bus.vs_i;
            bus.meas_vld_o <= 1'b0;
            if (pix) begin
                bus.x_o <= x_base;
                bus.y_o <= ycnt;
            end

            case (state)
                ST_SYNC: begin
                    if (!bus.vs_i) begin
                        state      <= ST_FWAIT;
                        ycnt       <= '0;
                        line_ref   <= '0;
                        err_sticky <= '0;
                    end
                end
                ST_FWAIT: begin
                    err_sticky <= err_now;
                    xcnt       <= x_next;
                    if (bus.vs_i) state <= bus.hs_i ? ST_HBLANK : ST_LINE;
                end
                default: begin
                    if (frame_end) begin
                        // The closing line (if any) is folded in via y_next/ref_next.
                        bus.meas_vld_o  <= 1'b1;
                        bus.width_o     <= ref_next;
                        bus.height_o    <= y_next;
                        bus.frame_cnt_o <= bus.frame_cnt_o + 16'd1;
                        bus.err_o       <= err_final;
                        ref_height      <= y_next;
                        ref_height_vld  <= 1'b1;
                        state           <= ST_FWAIT;
                        ycnt            <= '0;
                        line_ref        <= '0;
                        err_sticky      <= '0;
                    end else begin
                        xcnt       <= x_next;
                        ycnt       <= y_next;
                        line_ref   <= ref_next;
                        err_sticky <= err_now;
                        state      <= bus.hs_i ? ST_HBLANK : ST_LINE;
                    end
                end
            endcase
        end
    end

`ifdef VSTREAM_RX_CHECKSUM_EN
    logic [31:0] csum_acc, pix_sum;

    always_comb begin
        pix_sum = '0;
        for (int c = 0; c < 3; c++)
            pix_sum = pix_sum + 32'(bus.di_i[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_acc   <= '0;
            bus.csum_o <= '0;
        end else if (frame_end) begin
            bus.csum_o <= csum_acc;
            csum_acc   <= '0;
        end else if (state == ST_SYNC) begin
            csum_acc <= '0;
        end else if (pix) begin
            csum_acc <= csum_acc + pix_sum;
        end
    end
`endif

endmodule

// File: tb/tb_vstream_rx_meas.sv
// Bench for vstream_rx_meas: two instances (default and LINE_SIZE_MAX=8) fed the same
// random stream, checked against a frame-level model. Honours VSTREAM_RX_CHECKSUM_EN.
module tb_vstream_rx_meas;

  localparam int PW   = 8;
  localparam int XW_A = 13;
  localparam int XW_B = 4;
  localparam int YW   = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  vstream_rx_meas_if #(.PIXEL_WIDTH(PW), .XW(XW_A), .YW(YW)) sif_a ();
  vstream_rx_meas_if #(.PIXEL_WIDTH(PW), .XW(XW_B), .YW(YW)) sif_b ();

  vstream_rx_meas #(.PIXEL_WIDTH(PW)) dut_a (.clk(clk), .rst(rst), .bus(sif_a));
  vstream_rx_meas #(.PIXEL_WIDTH(PW), .LINE_SIZE_MAX(8)) dut_b (.clk(clk), .rst(rst), .bus(sif_b));

  // scoreboard: pixel item {8'h0, data[23:0], x[15:0], y[15:0]}
  // meas item {csum[31:0], fcnt[15:0], err[15:0], height[15:0], width[15:0]}
  logic [63:0]  exp_pix_a [$];
  logic [63:0]  exp_pix_b [$];
  logic [127:0] exp_meas_a [$];
  logic [127:0] exp_meas_b [$];

  // frame-level reference model state
  int          maxw [2];
  int          ref_h [2];
  bit          ref_vld [2];
  int          fcnt [2];
  int          last_x [2];
  int          last_y [2];
  int          last_w [2];
  int          last_hgt [2];
  bit          synced = 1'b0;
  bit          ones_data = 1'b0;
  bit          blank_seen = 1'b0;
  logic [31:0] frame_sum = '0;
  int          line_len [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push_pixel(input logic [23:0] d, input bit hs, input bit vs, input int k, input int ln);
    bit counted;
    counted = synced && vs && !hs;
    if (counted) frame_sum = frame_sum + 32'(d[7:0]) + 32'(d[15:8]) + 32'(d[23:16]);
    for (int i = 0; i < 2; i++) begin
      if (counted) begin
        last_x[i] = imin(k, maxw[i]);
        last_y[i] = ln;
      end
      if (i == 0) exp_pix_a.push_back({8'h0, d, 16'(last_x[i]), 16'(last_y[i])});
      else        exp_pix_b.push_back({8'h0, d, 16'(last_x[i]), 16'(last_y[i])});
    end
  endtask

  // driver: one stream cycle, applied 1 time unit after the rising edge
  task automatic drive_cycle(input bit de, input bit hs, input bit vs, input int k, input int ln);
    logic [23:0] d;
    d = ones_data ? 24'h010101 : 24'($urandom);
    @(posedge clk);
    #1;
    sif_a.di_i = d;  sif_a.de_i = de;  sif_a.hs_i = hs;  sif_a.vs_i = vs;
    sif_b.di_i = d;  sif_b.de_i = de;  sif_b.hs_i = hs;  sif_b.vs_i = vs;
    if (!rst) begin
      if (synced && de && (hs || !vs)) blank_seen = 1'b1;
      if (de) push_pixel(d, hs, vs, k, ln);
      if (!vs) synced = 1'b1;
    end
  endtask

  // gap_mode: 0 = de every clk, 1 = one idle clk before each pixel, 2 = random idle clks
  task automatic send_line(input int ln, input int len, input int gap_mode, input bit blank_de, input int hb);
    for (int h = 0; h < hb; h++) drive_cycle(blank_de && (h == hb - 1), 1'b1, 1'b1, 0, ln);
    for (int k = 0; k < len; k++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))
        drive_cycle(1'b0, 1'b0, 1'b1, 0, ln);
      drive_cycle(1'b1, 1'b0, 1'b1, k, ln);
    end
  endtask

  task automatic expect_meas();
    int nl;
    nl = line_len.size();
    for (int i = 0; i < 2; i++) begin
      int w;
      bit werr;
      bit ovf;
      bit herr;
      w = 0; werr = 1'b0; ovf = 1'b0;
      if (nl > 0) w = imin(line_len[0], maxw[i]);
      foreach (line_len[j]) begin
        if (line_len[j] > maxw[i]) ovf = 1'b1;
        if (j > 0 && imin(line_len[j], maxw[i]) != w) werr = 1'b1;
      end
      herr = ref_vld[i] && (nl != ref_h[i]);
      ref_h[i] = nl;
      ref_vld[i] = 1'b1;
      fcnt[i] = (fcnt[i] + 1) % 65536;
      last_w[i] = w;
      last_hgt[i] = nl;
      if (i == 0) exp_meas_a.push_back({32'h0, frame_sum, 16'(fcnt[i]), 12'h0, ovf, blank_seen, herr, werr, 16'(nl), 16'(w)});
      else        exp_meas_b.push_back({32'h0, frame_sum, 16'(fcnt[i]), 12'h0, ovf, blank_seen, herr, werr, 16'(nl), 16'(w)});
    end
  endtask

  task automatic send_frame(input int gap_mode, input bit coincident, input int blank_line);
    frame_sum = '0;
    blank_seen = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b1, 0, 0);
    for (int ln = 0; ln < line_len.size(); ln++)
      send_line(ln, line_len[ln], gap_mode, ln == blank_line, $urandom_range(1, 3));
    if (!(coincident && line_len.size() > 0))
      repeat ($urandom_range(1, 3)) drive_cycle(1'b0, 1'b1, 1'b1, 0, 0);
    expect_meas();
    drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
    repeat ($urandom_range(1, 4)) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic set_frame(input int nl, input int w);
    line_len.delete();
    for (int i = 0; i < nl; i++) line_len.push_back(w);
  endtask

  task automatic check_reset_outputs(input string who);
    check_eq({who, "_a_de"},     64'(sif_a.de_o), 64'd0);
    check_eq({who, "_a_x"},      64'(sif_a.x_o), 64'd0);
    check_eq({who, "_a_y"},      64'(sif_a.y_o), 64'd0);
    check_eq({who, "_a_meas"},   64'(sif_a.meas_vld_o), 64'd0);
    check_eq({who, "_a_width"},  64'(sif_a.width_o), 64'd0);
    check_eq({who, "_a_height"}, 64'(sif_a.height_o), 64'd0);
    check_eq({who, "_a_fcnt"},   64'(sif_a.frame_cnt_o), 64'd0);
    check_eq({who, "_a_err"},    64'(sif_a.err_o), 64'd0);
    check_eq({who, "_b_width"},  64'(sif_b.width_o), 64'd0);
    check_eq({who, "_b_fcnt"},   64'(sif_b.frame_cnt_o), 64'd0);
  endtask

  // monitor: outputs sampled on the falling edge
  logic [63:0]  pa, pb;
  logic [127:0] ma, mb;
  always @(negedge clk) begin
    if (!rst) begin
      if (sif_a.de_o) begin
        check_eq("pix_a_pending", 64'(exp_pix_a.size() > 0), 64'd1);
        if (exp_pix_a.size() > 0) begin
          pa = exp_pix_a.pop_front();
          check_eq("pix_a_data", 64'(sif_a.do_o), 64'(pa[55:32]));
          check_eq("pix_a_x", 64'(sif_a.x_o), 64'(pa[31:16]));
          check_eq("pix_a_y", 64'(sif_a.y_o), 64'(pa[15:0]));
        end
      end
      if (sif_b.de_o) begin
        check_eq("pix_b_pending", 64'(exp_pix_b.size() > 0), 64'd1);
        if (exp_pix_b.size() > 0) begin
          pb = exp_pix_b.pop_front();
          check_eq("pix_b_data", 64'(sif_b.do_o), 64'(pb[55:32]));
          check_eq("pix_b_x", 64'(sif_b.x_o), 64'(pb[31:16]));
          check_eq("pix_b_y", 64'(sif_b.y_o), 64'(pb[15:0]));
        end
      end
      if (sif_a.meas_vld_o) begin
        check_eq("meas_a_pending", 64'(exp_meas_a.size() > 0), 64'd1);
        if (exp_meas_a.size() > 0) begin
          ma = exp_meas_a.pop_front();
          check_eq("meas_a_width", 64'(sif_a.width_o), 64'(ma[15:0]));
          check_eq("meas_a_height", 64'(sif_a.height_o), 64'(ma[31:16]));
          check_eq("meas_a_err", 64'(sif_a.err_o), 64'(ma[47:32]));
          check_eq("meas_a_fcnt", 64'(sif_a.frame_cnt_o), 64'(ma[63:48]));
`ifdef VSTREAM_RX_CHECKSUM_EN
          check_eq("meas_a_csum", 64'(sif_a.csum_o), 64'(ma[95:64]));
`endif
        end
      end
      if (sif_b.meas_vld_o) begin
        check_eq("meas_b_pending", 64'(exp_meas_b.size() > 0), 64'd1);
        if (exp_meas_b.size() > 0) begin
          mb = exp_meas_b.pop_front();
          check_eq("meas_b_width", 64'(sif_b.width_o), 64'(mb[15:0]));
          check_eq("meas_b_height", 64'(sif_b.height_o), 64'(mb[31:16]));
          check_eq("meas_b_err", 64'(sif_b.err_o), 64'(mb[47:32]));
          check_eq("meas_b_fcnt", 64'(sif_b.frame_cnt_o), 64'(mb[63:48]));
`ifdef VSTREAM_RX_CHECKSUM_EN
          check_eq("meas_b_csum", 64'(sif_b.csum_o), 64'(mb[95:64]));
`endif
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    maxw[0] = 4096;
    maxw[1] = 8;
    for (int i = 0; i < 2; i++) begin
      ref_h[i] = 0; ref_vld[i] = 1'b0; fcnt[i] = 0;
      last_x[i] = 0; last_y[i] = 0; last_w[i] = 0; last_hgt[i] = 0;
    end
    sif_a.di_i = '0; sif_a.de_i = 1'b0; sif_a.hs_i = 1'b1; sif_a.vs_i = 1'b0;
    sif_b.di_i = '0; sif_b.de_i = 1'b0; sif_b.hs_i = 1'b1; sif_b.vs_i = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (2) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);

    // two 24x24 frames, de every clk
    set_frame(24, 24);
    send_frame(0, 1'b0, -1);
    send_frame(0, 1'b0, -1);

    // 96x96, alternate-clk de, vs fall coincident with last hs rise
    set_frame(96, 96);
    send_frame(1, 1'b1, -1);

    // 16x16 with a short line 5, then clean
    set_frame(16, 16);
    line_len[5] = 15;
    send_frame(0, 1'b0, -1);
    set_frame(16, 16);
    send_frame(0, 1'b0, -1);

    // height change 16 -> 15
    send_frame(2, 1'b0, -1);
    set_frame(15, 16);
    send_frame(2, 1'b0, -1);

    // de during hblank
    set_frame(16, 16);
    send_frame(0, 1'b0, 3);

    // zero-line frame
    set_frame(0, 0);
    send_frame(0, 1'b0, -1);

    // 10-pixel lines saturate the LINE_SIZE_MAX=8 instance
    set_frame(6, 10);
    send_frame(2, 1'b1, -1);

    // reset asserted inside line 2 (third line) and released mid-frame
    set_frame(16, 16);
    frame_sum = '0;
    blank_seen = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b1, 0, 0);
    send_line(0, 16, 0, 1'b0, 2);
    send_line(1, 16, 0, 1'b0, 2);
    drive_cycle(1'b0, 1'b1, 1'b1, 0, 2);
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b0, 1'b1, k, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_pix_a.delete(); exp_pix_b.delete();
    exp_meas_a.delete(); exp_meas_b.delete();
    synced = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ref_vld[i] = 1'b0; fcnt[i] = 0; last_x[i] = 0; last_y[i] = 0;
    end
    repeat (2) drive_cycle(1'b1, 1'b0, 1'b1, 5, 2);
    drive_cycle(1'b0, 1'b0, 1'b1, 0, 2);
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    for (int k = 8; k < 16; k++) drive_cycle(1'b1, 1'b0, 1'b1, k, 2);
    for (int ln = 3; ln < 16; ln++) send_line(ln, 16, 0, 1'b0, 2);
    drive_cycle(1'b0, 1'b1, 1'b1, 0, 0);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
    ones_data = 1'b1;
    send_frame(0, 1'b0, -1);
    ones_data = 1'b0;

    // random geometry
    for (int f = 0; f < 6; f++) begin
      int nl;
      int w;
      nl = $urandom_range(1, 12);
      w = $urandom_range(2, 20);
      set_frame(nl, w);
      if ($urandom_range(0, 1) == 1) line_len[$urandom_range(0, nl - 1)] = w - 1;
      send_frame(2, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1);
    end

    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    check_eq("pix_a_left", 64'(exp_pix_a.size()), 64'd0);
    check_eq("pix_b_left", 64'(exp_pix_b.size()), 64'd0);
    check_eq("meas_a_left", 64'(exp_meas_a.size()), 64'd0);
    check_eq("meas_b_left", 64'(exp_meas_b.size()), 64'd0);
    check_eq("hold_a_width", 64'(sif_a.width_o), 64'(last_w[0]));
    check_eq("hold_a_height", 64'(sif_a.height_o), 64'(last_hgt[0]));
    check_eq("hold_b_width", 64'(sif_b.width_o), 64'(last_w[1]));
    check_eq("hold_a_fcnt", 64'(sif_a.frame_cnt_o), 64'(fcnt[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
